apb_slave_regfile: RTL
======================

Name: apb_slave_regfile

Overview:
- APB responder (completer) holding a small register file; it is the far end of our APB master on the same bus.
- It decodes SETUP/ACCESS phases, inserts a programmable number of wait states, and commits writes or returns read data.
- It flags out-of-range and illegal accesses with pslverr.
- It exports the register contents and a write strobe to the local logic.

Parameters:
- DATA_WIDTH, 8, width of pwdata/prdata and of each register
- ADDR_WIDTH, 8, width of paddr; paddr is a word index (no byte offset)
- NUM_REGS, 16, number of registers; legal indices are 0..NUM_REGS-1; must be 2..2^ADDR_WIDTH
- WAIT_CYCLES, 1, ACCESS cycles with pready low before completion; range 0..15
- ID_VALUE, 8'hA5, constant value of read-only register 0

Ports:
- clk  in  1  clock; all logic on its rising edge
- rstn  in  1  reset; synchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  register index
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data; valid only while pready=1, read, no error; else 0
- pready  out  1  transfer completion
- pslverr  out  1  error response; valid only with pready=1
- reg_flat  out  NUM_REGS*DATA_WIDTH  all registers concatenated; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse  out  1  one-cycle pulse on each committed write
- wr_idx  out  ADDR_WIDTH  index of the last committed write; holds its value between writes

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state = IDLE, wait counter = 0.
  - Registers 1..NUM_REGS-1 = 0; register 0 always equals ID_VALUE.
  - pready=0, pslverr=0, prdata=0, wr_pulse=0, wr_idx=0.
  - Reset asserted mid-transfer aborts it; no write is committed.
- State machine, 2 states:
  - IDLE: psel=1 and penable=0 (SETUP phase) at an edge -> go to ACCESS and load cnt = WAIT_CYCLES. Otherwise stay in IDLE.
  - ACCESS: psel=0 -> go to IDLE; the transfer is abandoned, nothing is committed, no error.
  - ACCESS: psel=1, penable=1, cnt!=0 -> cnt decrements; stay in ACCESS.
  - ACCESS: cnt==0 -> completion cycle; go to IDLE at the next edge.
  - ACCESS: psel=1 and penable=0 is a protocol violation -> treat as a new SETUP (reload cnt, stay in ACCESS).
- Outputs:
  - pready is combinational = (state==ACCESS && psel && penable && cnt==0).
  - Completion therefore falls on ACCESS cycle WAIT_CYCLES+1; WAIT_CYCLES=0 means zero wait states.
- Error decode (combinational, sampled in the completion cycle):
  - err = (paddr >= NUM_REGS) or (pwrite && paddr==0).
  - pslverr = pready && err.
- Write: on the completion edge with pwrite=1 and err=0:
  - reg[paddr] <= pwdata.
  - wr_pulse is 1 for the following cycle only.
  - wr_idx <= paddr.
  - A write with err=1 changes nothing and produces no wr_pulse.
- Read:
  - prdata = reg[paddr] during the completion cycle when pwrite=0 and err=0; 0 otherwise, including on error.
  - Reads have no side effects.
- Back-to-back transfers: the master's SETUP immediately follows completion. The block is in IDLE that cycle, so the next transfer starts with no idle gap.
- Address and data are used as presented in the completion cycle; APB holds them stable through ACCESS.
- Read-after-write to the same index in consecutive transfers returns the new value.

Test Plan:
1. Reset, then read idx 0 with WAIT_CYCLES=1 -> pready low in first ACCESS cycle, high in second; prdata=8'hA5, pslverr=0.
2. Write 8'h3C to idx 5, then read idx 5 back-to-back -> reg_flat[47:40]=8'h3C, wr_pulse one cycle with wr_idx=5, read returns 8'h3C; check no idle cycle between transfers.
3. Write idx 0 and write idx 16 (NUM_REGS=16) -> pslverr=1 with pready in both; register contents unchanged, no wr_pulse; read idx 20 -> pslverr=1, prdata=0.
4. WAIT_CYCLES=0 build: write 8'hFF to idx 15 -> pready in first ACCESS cycle; reg 15 = 8'hFF.
5. Start a write to idx 3 and drop psel during the wait state -> no commit, block returns to IDLE; next SETUP is accepted normally.
6. Assert rstn=0 mid-ACCESS of a write to idx 2 holding 8'h11 -> after reset idx 2 reads 0, pready=0; a subsequent transfer completes normally.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a NUM_REGS x DATA_WIDTH register file; register 0 is a read-only ID.
// Completes WAIT_CYCLES+1 ACCESS cycles after SETUP; pready low stalls the master until then.
module apb_slave_regfile #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat,
  output logic                           wr_pulse,
  output logic [ADDR_WIDTH-1:0]          wr_idx
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [3:0]          CNT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  state_t                state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] store [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  setup;
  logic                  active;
  logic                  err;
  logic                  commit;

  assign setup  = psel && !penable;
  assign active = psel && penable;

  // Extra MSB keeps the range check correct when NUM_REGS == 2^ADDR_WIDTH.
  assign err     = ({1'b0, paddr} >= REG_LIMIT) || (pwrite && (paddr == '0));
  assign pready  = (state == ACCESS) && active && (cnt == 4'd0);
  assign pslverr = pready && err;
  assign commit  = pready && pwrite && !err;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (paddr == ADDR_WIDTH'(i)) begin
        rd_sel = store[i];
      end
    end
  end

  assign prdata = (pready && !pwrite && !err) ? rd_sel : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
    end else begin
      wr_pulse <= commit;
      if (commit) begin
        wr_idx <= paddr;
      end
      case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            cnt   <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (!penable) begin
            // SETUP seen mid-transfer restarts the wait count.
            cnt <= CNT_LOAD;
          end else if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    store[0] <= ID_VALUE;
    if (!rstn) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        store[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit && (paddr == ADDR_WIDTH'(i))) begin
          store[i] <= pwdata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[g*DATA_WIDTH +: DATA_WIDTH] = store[g];
  end

endmodule
